// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update bus between the core and the branch predictor.
// The core drives the master side; the predictor implements the slave side.
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_f;
  logic              pred_taken_f;
  logic [ADDR_W-1:0] pred_next_pc_f;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;

  modport master (
    output pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken_f, pred_next_pc_f, mispredict
  );

  modport slave (
    input  pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken_f, pred_next_pc_f, mispredict
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, zero-latency
// next-PC lookup, execute-stage training, mispredict flag and saturating perf counters.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_predictor_if.slave bp,
  output logic [CNT_W-1:0] lookup_hits,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef logic [CTR_W-1:0] ctr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_WT  = ctr_t'(1 << (CTR_W - 1));
  localparam ctr_t CTR_WNT = ctr_t'((1 << (CTR_W - 1)) - 1);

  logic              valid_q  [ENTRIES];
  logic              jump_q   [ENTRIES];
  ctr_t              ctr_q    [ENTRIES];
  tag_t              tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  cnt_t lookup_hits_q, branch_count_q, mispredict_count_q;

  // Fetch-side lookup
  idx_t              f_idx;
  tag_t              f_tag;
  logic              f_hit;
  logic [ADDR_W-1:0] f_pc_plus4;

  assign f_idx      = bp.pc_f[IDX_W+1:2];
  assign f_tag      = bp.pc_f[ADDR_W-1:IDX_W+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_pc_plus4 = bp.pc_f + ADDR_W'(4);

  assign bp.pred_taken_f   = f_hit && (jump_q[f_idx] || ctr_q[f_idx][CTR_W-1]);
  assign bp.pred_next_pc_f = bp.pred_taken_f ? target_q[f_idx] : f_pc_plus4;

  // Execute-side resolution
  idx_t u_idx;
  tag_t u_tag;
  ctr_t u_ctr;
  logic u_hit;
  logic unused_upd_lsb;

  assign u_idx          = bp.upd_pc[IDX_W+1:2];
  assign u_tag          = bp.upd_pc[ADDR_W-1:IDX_W+2];
  assign u_ctr          = ctr_q[u_idx];
  assign u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign unused_upd_lsb = ^bp.upd_pc[1:0];

  // Gated by rst_n so a core still driving execute during reset sees no redirect.
  assign bp.mispredict = rst_n && bp.upd_valid &&
                         ((bp.upd_pred_taken != bp.upd_taken) ||
                          (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));

  logic entry_we, tag_we, tgt_we, jump_d;
  ctr_t ctr_d;

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    entry_we = 1'b0;
    tag_we   = 1'b0;
    tgt_we   = 1'b0;
    jump_d   = jump_q[u_idx];
    ctr_d    = u_ctr;
    if (bp.upd_valid) begin
      if (u_hit) begin
        entry_we = 1'b1;
        tgt_we   = bp.upd_taken;
        jump_d   = bp.upd_is_jump;
        if (bp.upd_is_jump)    ctr_d = CTR_MAX;
        else if (bp.upd_taken) ctr_d = (u_ctr == CTR_MAX) ? CTR_MAX : u_ctr + 1'b1;
        else                   ctr_d = (u_ctr == '0) ? '0 : u_ctr - 1'b1;
      end else if (bp.upd_taken) begin
        entry_we = 1'b1;
        tag_we   = 1'b1;
        tgt_we   = 1'b1;
        jump_d   = bp.upd_is_jump;
        ctr_d    = bp.upd_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; this is what gives same-cycle lookups the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (entry_we) begin
      valid_q[u_idx] <= 1'b1;
      jump_q[u_idx]  <= jump_d;
      ctr_q[u_idx]   <= ctr_d;
    end
  end

  // NOTE: tag and target storage is deliberately not reset; valid_q gates every use,
  // so leaving them out keeps the array as plain RAM-style flops.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[u_idx]    <= u_tag;
    if (tgt_we) target_q[u_idx] <= bp.upd_target;
  end

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_hits_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (f_hit)         lookup_hits_q      <= sat_inc(lookup_hits_q);
      if (bp.upd_valid)  branch_count_q     <= sat_inc(branch_count_q);
      if (bp.mispredict) mispredict_count_q <= sat_inc(mispredict_count_q);
    end
  end

  assign lookup_hits      = lookup_hits_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: default instance plus a small-counter
// instance for saturation, sharing clock and reset.
module tb_branch_predictor;

  localparam logic [31:0] IDLE_PC = 32'h0000_0FFC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(32)) bus  ();
  branch_predictor_if #(.ADDR_W(32)) bus2 ();

  logic [15:0] lookup_hits, branch_count, mispredict_count;
  logic [2:0]  s_hits, s_br, s_mp;

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bp               (bus.slave),
    .lookup_hits      (lookup_hits),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_predictor #(.ADDR_W(32), .ENTRIES(2), .CTR_W(2), .CNT_W(3)) dut_small (
    .clk              (clk),
    .rst_n            (rst_n),
    .bp               (bus2.slave),
    .lookup_hits      (s_hits),
    .branch_count     (s_br),
    .mispredict_count (s_mp)
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] npc;
    logic        mp;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt_hits = 0, cnt_br = 0, cnt_mp = 0;

  // Scoreboard consumer: pops one expectation per sample event.
  always @(sample_ev) begin
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: sample with no expected entry at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (bus.pred_taken_f !== e.pt || bus.pred_next_pc_f !== e.npc || bus.mispredict !== e.mp) begin
        n_err++;
        $display("FAIL %s: got taken=%0b next=%h misp=%0b, want taken=%0b next=%h misp=%0b",
                 e.name, bus.pred_taken_f, bus.pred_next_pc_f, bus.mispredict, e.pt, e.npc, e.mp);
      end
    end
  end

  task automatic expect_out(input string name, input logic pt, input logic [31:0] npc,
                            input logic mp);
    exp_t e;
    e.name = name; e.pt = pt; e.npc = npc; e.mp = mp;
    sb_q.push_back(e);
    #1 -> sample_ev;
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic j, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    bus.upd_valid       = v;
    bus.upd_pc          = pc;
    bus.upd_is_jump     = j;
    bus.upd_taken       = t;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = pt;
    bus.upd_pred_target = ptg;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic pt,
                      input logic [31:0] npc);
    @(negedge clk);
    bus.pc_f = pc;
    expect_out(name, pt, npc, 1'b0);
    bus.pc_f = IDLE_PC;
  endtask

  task automatic upd_step(input string name, input logic [31:0] pc, input logic j,
                          input logic t, input logic [31:0] tgt, input logic pt,
                          input logic [31:0] ptg, input logic exp_misp);
    @(negedge clk);
    bus.pc_f = IDLE_PC;
    set_upd(1'b1, pc, j, t, tgt, pt, ptg);
    expect_out(name, 1'b0, IDLE_PC + 32'd4, exp_misp);
    @(posedge clk);
    #1;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cnt_br++;
    if (exp_misp) cnt_mp++;
  endtask

  task automatic test_reset();
    bus.pc_f = 32'h40;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus2.pc_f = 32'h0; bus2.upd_valid = 1'b0; bus2.upd_pc = 32'h0; bus2.upd_is_jump = 1'b0;
    bus2.upd_taken = 1'b0; bus2.upd_target = 32'h0; bus2.upd_pred_taken = 1'b0;
    bus2.upd_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    look("reset_lookup", 32'h40, 1'b0, 32'h44);
    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    n_vec++;
    if (lookup_hits !== 16'(cnt_hits) || branch_count !== 16'(cnt_br) || mispredict_count !== 16'(cnt_mp)) begin
      n_err++;
      $display("FAIL reset counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               lookup_hits, branch_count, mispredict_count, cnt_hits, cnt_br, cnt_mp);
    end
  endtask

  task automatic test_train();
    upd_step("alloc_misp", 32'h40, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44, 1'b1);
    look("alloc_hit", 32'h40, 1'b1, 32'h20);
    @(negedge clk);
    bus.pc_f = 32'h40;
    repeat (3) @(posedge clk);
    #1 bus.pc_f = IDLE_PC;
    cnt_hits += 3;
    n_vec++;
    if (lookup_hits !== 16'(cnt_hits) || branch_count !== 16'(cnt_br) || mispredict_count !== 16'(cnt_mp)) begin
      n_err++;
      $display("FAIL train counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               lookup_hits, branch_count, mispredict_count, cnt_hits, cnt_br, cnt_mp);
    end
  endtask

  task automatic test_direction_ctr();
    upd_step("nt1",    32'h40, 1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b1);
    look("ctr1_nt", 32'h40, 1'b0, 32'h44);
    upd_step("nt2",    32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 1'b0);
    look("ctr0_nt", 32'h40, 1'b0, 32'h44);
    upd_step("t1",     32'h40, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
    look("ctr1_after_t", 32'h40, 1'b0, 32'h44);
    upd_step("t2_tgt", 32'h40, 1'b0, 1'b1, 32'h20, 1'b1, 32'h24, 1'b1);
    look("ctr2_taken", 32'h40, 1'b1, 32'h20);
    upd_step("t3_new", 32'h40, 1'b0, 1'b1, 32'h30, 1'b1, 32'h20, 1'b1);
    look("target_upd", 32'h40, 1'b1, 32'h30);
    upd_step("t4_sat", 32'h40, 1'b0, 1'b1, 32'h30, 1'b1, 32'h30, 1'b0);
    upd_step("nt_sat", 32'h40, 1'b0, 1'b0, 32'h0,  1'b1, 32'h30, 1'b1);
    look("sat_no_wrap", 32'h40, 1'b1, 32'h30);
    upd_step("nt_ctr1", 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    look("ctr1_again", 32'h40, 1'b0, 32'h44);
    n_vec++;
    if (lookup_hits !== 16'(cnt_hits) || branch_count !== 16'(cnt_br) || mispredict_count !== 16'(cnt_mp)) begin
      n_err++;
      $display("FAIL ctr counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               lookup_hits, branch_count, mispredict_count, cnt_hits, cnt_br, cnt_mp);
    end
  endtask

  task automatic test_alias();
    upd_step("retrain", 32'h40, 1'b0, 1'b1, 32'h30, 1'b0, 32'h44, 1'b1);
    look("retrain_hit", 32'h40, 1'b1, 32'h30);
    look("alias_miss", 32'h80, 1'b0, 32'h84);
    upd_step("alias_nt", 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h84, 1'b0);
    look("alias_intact", 32'h40, 1'b1, 32'h30);
    look("alias_still_miss", 32'h80, 1'b0, 32'h84);
  endtask

  task automatic test_jump_same_cycle();
    upd_step("jump_alloc", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1);
    for (int i = 0; i < 3; i++)
      upd_step("jump_nt", 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    look("jump_sticky", 32'h100, 1'b1, 32'h200);
    look("evicted_40", 32'h40, 1'b0, 32'h44);
    @(negedge clk);
    bus.pc_f = 32'h3C;
    set_upd(1'b1, 32'h3C, 1'b0, 1'b1, 32'h80, 1'b0, 32'h40);
    expect_out("same_cycle_old", 1'b0, 32'h40, 1'b1);
    @(posedge clk);
    #1;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.pc_f = IDLE_PC;
    cnt_br++;
    cnt_mp++;
    look("same_cycle_new", 32'h3C, 1'b1, 32'h80);
    n_vec++;
    if (lookup_hits !== 16'(cnt_hits) || branch_count !== 16'(cnt_br) || mispredict_count !== 16'(cnt_mp)) begin
      n_err++;
      $display("FAIL jump counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               lookup_hits, branch_count, mispredict_count, cnt_hits, cnt_br, cnt_mp);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    bus2.pc_f = 32'h40; bus2.upd_valid = 1'b1; bus2.upd_pc = 32'h40; bus2.upd_is_jump = 1'b0;
    bus2.upd_taken = 1'b1; bus2.upd_target = 32'h8; bus2.upd_pred_taken = 1'b0;
    bus2.upd_pred_target = 32'h44;
    repeat (7) @(posedge clk);
    #1;
    n_vec++;
    if (s_hits !== 3'd6 || s_br !== 3'd7 || s_mp !== 3'd7) begin
      n_err++;
      $display("FAIL sat_pre counters: got %0d/%0d/%0d, want 6/7/7", s_hits, s_br, s_mp);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (s_hits !== 3'd7 || s_br !== 3'd7 || s_mp !== 3'd7) begin
      n_err++;
      $display("FAIL sat_hold counters: got %0d/%0d/%0d, want 7/7/7", s_hits, s_br, s_mp);
    end
    n_vec++;
    if (bus2.pred_taken_f !== 1'b1 || bus2.pred_next_pc_f !== 32'h8) begin
      n_err++;
      $display("FAIL small_lookup: got taken=%0b next=%h, want taken=1 next=00000008",
               bus2.pred_taken_f, bus2.pred_next_pc_f);
    end
    bus2.upd_valid = 1'b0;
    bus2.pc_f = 32'h0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.pc_f = 32'h100;
    set_upd(1'b1, 32'h24, 1'b0, 1'b1, 32'h300, 1'b0, 32'h28);
    expect_out("pre_reset", 1'b1, 32'h200, 1'b1);
    rst_n = 1'b0;
    cnt_hits = 0; cnt_br = 0; cnt_mp = 0;
    expect_out("in_reset", 1'b0, 32'h104, 1'b0);
    n_vec++;
    if (lookup_hits !== 16'd0 || branch_count !== 16'd0 || mispredict_count !== 16'd0 ||
        s_hits !== 3'd0 || s_br !== 3'd0 || s_mp !== 3'd0) begin
      n_err++;
      $display("FAIL reset_clear counters: got %0d/%0d/%0d small %0d/%0d/%0d, want all 0",
               lookup_hits, branch_count, mispredict_count, s_hits, s_br, s_mp);
    end
    @(posedge clk);
    #1;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.pc_f = IDLE_PC;
    rst_n = 1'b1;
    look("post_reset_jump", 32'h100, 1'b0, 32'h104);
    look("post_reset_inflight", 32'h24, 1'b0, 32'h28);
    look("post_reset_3c", 32'h3C, 1'b0, 32'h40);
    n_vec++;
    if (lookup_hits !== 16'(cnt_hits) || branch_count !== 16'(cnt_br) || mispredict_count !== 16'(cnt_mp)) begin
      n_err++;
      $display("FAIL post_reset counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               lookup_hits, branch_count, mispredict_count, cnt_hits, cnt_br, cnt_mp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_train();
    test_direction_ctr();
    test_alias();
    test_jump_same_cycle();
    test_saturation();
    test_async_reset();
    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Provides a next-PC prediction to fetch in the same cycle as the instruction-memory read.
- Trains from the execute stage when a branch or jump resolves.
- Also flags mispredictions and keeps saturating performance counters, so the core can replace the fixed pc+4 / execute-redirect policy.

Parameters:
ADDR_W, 32, PC / target width in bits
ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width in bits; ≥1
CNT_W, 16, performance counter width in bits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_f  in  ADDR_W  fetch PC being looked up
pred_taken_f  out  1  prediction: redirect fetch
pred_next_pc_f  out  ADDR_W  predicted next PC
upd_valid  in  1  resolved branch/jump present in execute this cycle
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_is_jump  in  1  resolved instruction is an unconditional jump
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual taken target
upd_pred_taken  in  1  prediction originally made for this instruction, piped from fetch
upd_pred_target  in  ADDR_W  predicted next PC originally made, piped from fetch
mispredict  out  1  execute must redirect and flush
lookup_hits  out  CNT_W  count of lookups that hit
branch_count  out  CNT_W  count of upd_valid cycles
mispredict_count  out  CNT_W  count of mispredict cycles

Behaviour:
- Address fields:
  - idx = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Per-entry state: valid, tag, target, jump flag, ctr[CTR_W-1:0].
- Reset (rst_n low, asynchronous):
  - all valid=0, all ctr = 2^(CTR_W-1)-1 (weakly not-taken), jump flags 0.
  - All perf counters are 0.
  - Outputs during reset: pred_taken_f=0, pred_next_pc_f=pc_f+4, mispredict=0.
  - Reset asserted mid-training discards any in-flight update.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag matches.
  - pred_taken_f = hit && (jump flag || ctr MSB == 1).
  - pred_next_pc_f = pred_taken_f ? target[idx] : pc_f+4, computed modulo 2^ADDR_W.
- Mispredict (combinational):
  - mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)).
- Update (registered, on rising clk when upd_valid=1), with uidx/utag taken from upd_pc:
  - Entry hit (valid and tag match):
    - upd_taken: ctr saturating increment (stays at 2^CTR_W-1); target <= upd_target.
    - Not taken: ctr saturating decrement (stays at 0).
    - jump flag <= upd_is_jump. A jump entry's ctr is forced to max.
  - Entry miss and upd_taken: allocate/overwrite:
    - valid=1, tag=utag, target=upd_target, jump flag=upd_is_jump.
    - ctr = 2^(CTR_W-1) (weakly taken), or max if jump.
  - Entry miss and not taken: no state change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state; the new state is visible from the next cycle.
- upd_valid=0: no state change; mispredict=0.
- Perf counters increment on the rising edge and saturate at 2^CNT_W-1 (no wrap):
  - lookup_hits increments every cycle hit=1 while out of reset.
  - branch_count increments on upd_valid.
  - mispredict_count increments on mispredict.
- Single clock domain. No internal stall input: fetch holding pc_f stable repeats the same lookup, which is harmless apart from lookup_hits.

Test Plan (defaults: ENTRIES=16, CTR_W=2, idx = pc[5:2]):
1. Release reset, pc_f=0x40:
   -> pred_taken_f=0, pred_next_pc_f=0x44, all counters 0.
2. Update upd_pc=0x40, taken, target 0x20, upd_pred_taken=0:
   -> mispredict=1 that cycle.
   -> Next cycle pc_f=0x40 gives pred_taken_f=1, pred_next_pc_f=0x20.
   -> branch_count=1, mispredict_count=1.
3. From case 2, two not-taken updates at 0x40:
   -> after the first, ctr=1 and pred_taken_f=0.
   -> after the second, ctr=0.
   -> a fifth taken-run of 4 updates ends with ctr saturated at 3, not wrapped.
4. Alias: entry 0x40 valid, lookup pc_f=0x80 (same idx 0, different tag):
   -> miss, pred_next_pc_f=0x84.
   -> A not-taken update at 0x80 leaves the 0x40 entry intact.
5. Jump: update 0x100, upd_is_jump=1, target 0x200; then three not-taken-flagged updates at 0x100:
   -> lookup 0x100 still predicts taken to 0x200.
   -> Same-cycle lookup+update on a new index shows the old (miss) result in that cycle.
6. Assert rst_n low asynchronously mid-sequence (between clock edges):
   -> pred_taken_f drops to 0 immediately.
   -> All counters read 0.
   -> After release, previously trained PCs miss.
